lsu_lq_rr: RTL and testbench

// - Parametrised load queue: tracks issued loads from allocation until ROB retirement.
// - Replays cache-missed loads on MHQ fill, using a round-robin replay arbiter.
// - Flags loads as mis-speculated when a retiring store's byte range overlaps the load's byte range.
// - Sits between LSU_ID (allocation), LSU_EX (replay/update), SQ (store retire) and ROB (load retire).

---
 rtl/lsu_lq_rr_pkg.sv | 38 +++
 rtl/lsu_lq_rr_arbiter.sv | 37 +++
 rtl/lsu_lq_rr.sv | 166 ++++++++++++++++
 tb/tb_lsu_lq_rr.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_lq_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_lq_rr_pkg
// Brief   : Shared types and helpers for the load queue.
// Revision: 1.0
// ============================================================================
package lsu_lq_rr_pkg;

    localparam int LQ_DEPTH_DEFAULT = 8;

    typedef enum logic [3:0] {
        LSU_FUNC_LB  = 4'd0,
        LSU_FUNC_LH  = 4'd1,
        LSU_FUNC_LW  = 4'd2,
        LSU_FUNC_LBU = 4'd3,
        LSU_FUNC_LHU = 4'd4,
        LSU_FUNC_SB  = 4'd5,
        LSU_FUNC_SH  = 4'd6,
        LSU_FUNC_SW  = 4'd7
    } lsu_func_t;

    typedef struct packed {
        logic needs_replay;
        logic replay_rdy;
        logic retry;
        logic missp;
    } lq_slot_t;

    function automatic logic [2:0] lsu_size(input lsu_func_t func);
        case (func)
            LSU_FUNC_LB, LSU_FUNC_LBU, LSU_FUNC_SB: lsu_size = 3'd1;
            LSU_FUNC_LH, LSU_FUNC_LHU, LSU_FUNC_SH: lsu_size = 3'd2;
            default:                                lsu_size = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lq_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : lsu_lq_rr_arbiter
// Brief   : Round-robin pick of the first request at or after the pointer.
// Revision: 1.0
// ============================================================================
module lsu_lq_rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_oh,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] w_idx;

    // N is a power of two, so pointer arithmetic wraps for free
    always_comb begin
        grant_oh    = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_idx       = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = ptr + IDX_W'(k);
            if (!grant_valid && req[w_idx]) begin
                grant_valid     = 1'b1;
                grant_idx       = w_idx;
                grant_oh[w_idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_lq_rr.sv
`default_nettype none
// ============================================================================
// Module  : lsu_lq_rr
// Brief   : Load queue with miss replay (round-robin) and store-overlap check.
// Revision: 1.0
// ============================================================================
module lsu_lq_rr
    import lsu_lq_rr_pkg::*;
#(
    parameter int LQ_DEPTH      = LQ_DEPTH_DEFAULT,
    parameter int ADDR_WIDTH    = 32,
    parameter int ROB_TAG_WIDTH = 6,
    parameter int MHQ_TAG_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    output logic                     o_full,
    input  logic                     i_alloc_en,
    input  logic [ROB_TAG_WIDTH-1:0] i_alloc_tag,
    input  logic [ADDR_WIDTH-1:0]    i_alloc_addr,
    input  lsu_func_t                i_alloc_lsu_func,
    input  logic                     i_replay_stall,
    output logic                     o_replay_en,
    output logic [ROB_TAG_WIDTH-1:0] o_replay_tag,
    output logic [ADDR_WIDTH-1:0]    o_replay_addr,
    output lsu_func_t                o_replay_lsu_func,
    input  logic                     i_update_en,
    input  logic [ROB_TAG_WIDTH-1:0] i_update_tag,
    input  logic                     i_update_retry,
    input  logic [MHQ_TAG_WIDTH-1:0] i_update_mhq_tag,
    input  logic                     i_mhq_fill,
    input  logic [MHQ_TAG_WIDTH-1:0] i_mhq_fill_tag,
    input  logic                     i_sq_retire_en,
    input  logic [ADDR_WIDTH-1:0]    i_sq_retire_addr,
    input  lsu_func_t                i_sq_retire_lsu_func,
    input  logic                     i_rob_retire_en,
    input  logic [ROB_TAG_WIDTH-1:0] i_rob_retire_tag,
    output logic                     o_rob_retire_misspeculated
);

    localparam int LQ_IDX_WIDTH = $clog2(LQ_DEPTH);

    logic [LQ_DEPTH-1:0]      r_valid;
    logic [ADDR_WIDTH-1:0]    r_addr    [LQ_DEPTH];
    logic [ROB_TAG_WIDTH-1:0] r_tag     [LQ_DEPTH];
    lsu_func_t                r_func    [LQ_DEPTH];
    lq_slot_t                 r_slot    [LQ_DEPTH];
    logic [MHQ_TAG_WIDTH-1:0] r_mhq_tag [LQ_DEPTH];
    logic [LQ_IDX_WIDTH-1:0]  r_rr_ptr;

    logic [LQ_DEPTH-1:0]      w_free;
    logic [LQ_DEPTH-1:0]      w_alloc_sel;
    logic                     w_alloc_fire;
    logic [LQ_DEPTH-1:0]      w_retire_match;
    logic [LQ_DEPTH-1:0]      w_update_match;
    logic [LQ_DEPTH-1:0]      w_fill_wake;
    logic [LQ_DEPTH-1:0]      w_overlap;
    logic [LQ_DEPTH-1:0]      w_mark;
    logic [LQ_DEPTH-1:0]      w_missp_term;
    logic [LQ_DEPTH-1:0]      w_cand;
    logic [LQ_DEPTH-1:0]      w_grant_oh;
    logic [LQ_DEPTH-1:0]      w_grant_fire;
    logic [LQ_IDX_WIDTH-1:0]  w_grant_idx;
    logic                     w_grant_valid;
    logic                     w_update_wake;
    logic [ADDR_WIDTH:0]      w_st_start;
    logic [ADDR_WIDTH:0]      w_st_end;

    assign w_free       = ~r_valid;
    // Isolate the lowest set bit: lowest-index free entry
    assign w_alloc_sel  = w_free & (~w_free + {{(LQ_DEPTH-1){1'b0}}, 1'b1});
    assign o_full       = ~|w_free;
    assign w_alloc_fire = i_alloc_en & ~o_full;

    // An extra top bit keeps the exclusive end from wrapping at the top of memory
    assign w_st_start = {1'b0, i_sq_retire_addr};
    assign w_st_end   = w_st_start + {{(ADDR_WIDTH-2){1'b0}}, lsu_size(i_sq_retire_lsu_func)};

    // A fill arriving alongside the miss report would otherwise never be seen
    assign w_update_wake = i_mhq_fill & (i_update_retry | (i_mhq_fill_tag == i_update_mhq_tag));

    generate
        for (genvar i = 0; i < LQ_DEPTH; i++) begin : g_entry
            logic [ADDR_WIDTH:0] w_ld_start;
            logic [ADDR_WIDTH:0] w_ld_end;

            assign w_ld_start = {1'b0, r_addr[i]};
            assign w_ld_end   = w_ld_start + {{(ADDR_WIDTH-2){1'b0}}, lsu_size(r_func[i])};
            assign w_overlap[i] = (w_ld_start < w_st_end) && (w_st_start < w_ld_end);

            assign w_retire_match[i] = i_rob_retire_en & r_valid[i] & (r_tag[i] == i_rob_retire_tag);
            assign w_update_match[i] = i_update_en & r_valid[i] & (r_tag[i] == i_update_tag);
            assign w_fill_wake[i]    = i_mhq_fill & r_slot[i].needs_replay &
                                       (r_slot[i].retry | (i_mhq_fill_tag == r_mhq_tag[i]));
            assign w_mark[i]         = i_sq_retire_en & r_valid[i] & ~r_slot[i].needs_replay & w_overlap[i];
            assign w_missp_term[i]   = w_retire_match[i] &
                                       (r_slot[i].missp | (i_sq_retire_en & w_overlap[i]));
            assign w_cand[i]         = r_valid[i] & r_slot[i].replay_rdy & ~w_retire_match[i];
        end
    endgenerate

    assign o_rob_retire_misspeculated = |w_missp_term;

    lsu_lq_rr_arbiter #(
        .N     (LQ_DEPTH),
        .IDX_W (LQ_IDX_WIDTH)
    ) u_arbiter (
        .req         (w_cand),
        .ptr         (r_rr_ptr),
        .grant_oh    (w_grant_oh),
        .grant_idx   (w_grant_idx),
        .grant_valid (w_grant_valid)
    );

    assign o_replay_en       = w_grant_valid & ~i_replay_stall;
    assign w_grant_fire      = w_grant_oh & {LQ_DEPTH{o_replay_en}};
    assign o_replay_tag      = r_tag[w_grant_idx];
    assign o_replay_addr     = r_addr[w_grant_idx];
    assign o_replay_lsu_func = r_func[w_grant_idx];

    always_ff @(posedge clk) begin
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (rst || i_flush) begin
                r_valid[i] <= 1'b0;
                r_slot[i]  <= '0;
            end else if (w_retire_match[i]) begin
                r_valid[i] <= 1'b0;
            end else if (w_alloc_fire && w_alloc_sel[i]) begin
                r_valid[i] <= 1'b1;
                r_addr[i]  <= i_alloc_addr;
                r_tag[i]   <= i_alloc_tag;
                r_func[i]  <= i_alloc_lsu_func;
                r_slot[i]  <= '0;
            end else if (w_update_match[i]) begin
                r_slot[i].needs_replay <= 1'b1;
                r_slot[i].retry        <= i_update_retry;
                r_slot[i].replay_rdy   <= w_update_wake;
                r_slot[i].missp        <= 1'b0;
                r_mhq_tag[i]           <= i_update_mhq_tag;
            end else begin
                if (w_fill_wake[i]) begin
                    r_slot[i].replay_rdy <= 1'b1;
                end
                if (w_mark[i]) begin
                    r_slot[i].missp <= 1'b1;
                end
                // A granted entry leaves the replay pool even if a fill lands now
                if (w_grant_fire[i]) begin
                    r_slot[i].needs_replay <= 1'b0;
                    r_slot[i].replay_rdy   <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rr_ptr <= '0;
        end else if (o_replay_en) begin
            r_rr_ptr <= w_grant_idx + LQ_IDX_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_lq_rr.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_lq_rr
// Brief   : Directed self-checking bench for lsu_lq_rr.
// Revision: 1.0
// ============================================================================
module tb_lsu_lq_rr;
    import lsu_lq_rr_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_flush;
    logic        o_full;
    logic        i_alloc_en;
    logic [5:0]  i_alloc_tag;
    logic [31:0] i_alloc_addr;
    lsu_func_t   i_alloc_lsu_func;
    logic        i_replay_stall;
    logic        o_replay_en;
    logic [5:0]  o_replay_tag;
    logic [31:0] o_replay_addr;
    lsu_func_t   o_replay_lsu_func;
    logic        i_update_en;
    logic [5:0]  i_update_tag;
    logic        i_update_retry;
    logic [1:0]  i_update_mhq_tag;
    logic        i_mhq_fill;
    logic [1:0]  i_mhq_fill_tag;
    logic        i_sq_retire_en;
    logic [31:0] i_sq_retire_addr;
    lsu_func_t   i_sq_retire_lsu_func;
    logic        i_rob_retire_en;
    logic [5:0]  i_rob_retire_tag;
    logic        o_rob_retire_misspeculated;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_lq_rr dut (
        .clk                        (clk),
        .rst                        (rst),
        .i_flush                    (i_flush),
        .o_full                     (o_full),
        .i_alloc_en                 (i_alloc_en),
        .i_alloc_tag                (i_alloc_tag),
        .i_alloc_addr               (i_alloc_addr),
        .i_alloc_lsu_func           (i_alloc_lsu_func),
        .i_replay_stall             (i_replay_stall),
        .o_replay_en                (o_replay_en),
        .o_replay_tag               (o_replay_tag),
        .o_replay_addr              (o_replay_addr),
        .o_replay_lsu_func          (o_replay_lsu_func),
        .i_update_en                (i_update_en),
        .i_update_tag               (i_update_tag),
        .i_update_retry             (i_update_retry),
        .i_update_mhq_tag           (i_update_mhq_tag),
        .i_mhq_fill                 (i_mhq_fill),
        .i_mhq_fill_tag             (i_mhq_fill_tag),
        .i_sq_retire_en             (i_sq_retire_en),
        .i_sq_retire_addr           (i_sq_retire_addr),
        .i_sq_retire_lsu_func       (i_sq_retire_lsu_func),
        .i_rob_retire_en            (i_rob_retire_en),
        .i_rob_retire_tag           (i_rob_retire_tag),
        .o_rob_retire_misspeculated (o_rob_retire_misspeculated)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; i_flush = 1'b0;
        i_alloc_en = 1'b0; i_alloc_tag = '0; i_alloc_addr = '0; i_alloc_lsu_func = LSU_FUNC_LW;
        i_replay_stall = 1'b0;
        i_update_en = 1'b0; i_update_tag = '0; i_update_retry = 1'b0; i_update_mhq_tag = '0;
        i_mhq_fill = 1'b0; i_mhq_fill_tag = '0;
        i_sq_retire_en = 1'b0; i_sq_retire_addr = '0; i_sq_retire_lsu_func = LSU_FUNC_SW;
        i_rob_retire_en = 1'b0; i_rob_retire_tag = '0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read before the next one
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [5:0] tag, input logic [31:0] addr, input lsu_func_t f);
        idle();
        i_alloc_en = 1'b1; i_alloc_tag = tag; i_alloc_addr = addr; i_alloc_lsu_func = f;
        tick();
        idle();
    endtask

    task automatic update(input logic [5:0] tag, input logic retry, input logic [1:0] mtag);
        idle();
        i_update_en = 1'b1; i_update_tag = tag; i_update_retry = retry; i_update_mhq_tag = mtag;
        tick();
        idle();
    endtask

    task automatic flush();
        idle();
        i_flush = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        idle();
        #1;
        chk("reset_full", 32'(o_full), 32'd0);
        chk("reset_replay_en", 32'(o_replay_en), 32'd0);
        chk("reset_missp", 32'(o_rob_retire_misspeculated), 32'd0);

        // Fill the queue, then a dropped 9th alloc, then free tag 3
        for (int i = 0; i < 8; i++) alloc(6'(i), 32'h1000 + 32'(i) * 32'h40, LSU_FUNC_LW);
        chk("full_after_8", 32'(o_full), 32'd1);
        alloc(6'd8, 32'h2000, LSU_FUNC_LW);
        chk("full_after_drop", 32'(o_full), 32'd1);
        i_rob_retire_en = 1'b1; i_rob_retire_tag = 6'd3;
        #1;
        chk("retire3_missp", 32'(o_rob_retire_misspeculated), 32'd0);
        tick();
        idle();
        chk("not_full_after_retire", 32'(o_full), 32'd0);
        alloc(6'd9, 32'h3000, LSU_FUNC_LW);
        chk("full_after_refill", 32'(o_full), 32'd1);
        flush();
        chk("flush_full", 32'(o_full), 32'd0);

        // Retired store overlapping an already executed load
        alloc(6'd10, 32'h100, LSU_FUNC_LW);
        i_sq_retire_en = 1'b1; i_sq_retire_addr = 32'h102; i_sq_retire_lsu_func = LSU_FUNC_SB;
        tick();
        idle();
        i_rob_retire_en = 1'b1; i_rob_retire_tag = 6'd10;
        #1;
        chk("sb_0x102_missp", 32'(o_rob_retire_misspeculated), 32'd1);
        tick();
        alloc(6'd11, 32'h100, LSU_FUNC_LW);
        i_sq_retire_en = 1'b1; i_sq_retire_addr = 32'h104; i_sq_retire_lsu_func = LSU_FUNC_SB;
        tick();
        idle();
        i_rob_retire_en = 1'b1; i_rob_retire_tag = 6'd11;
        #1;
        chk("sb_0x104_missp", 32'(o_rob_retire_misspeculated), 32'd0);
        tick();

        // Same-cycle store/load retire bypass
        alloc(6'd12, 32'h100, LSU_FUNC_LB);
        i_rob_retire_en = 1'b1; i_rob_retire_tag = 6'd12;
        i_sq_retire_en = 1'b1; i_sq_retire_addr = 32'h0FF; i_sq_retire_lsu_func = LSU_FUNC_SH;
        #1;
        chk("bypass_sh_0xff", 32'(o_rob_retire_misspeculated), 32'd1);
        tick();
        alloc(6'd13, 32'h100, LSU_FUNC_LB);
        i_rob_retire_en = 1'b1; i_rob_retire_tag = 6'd13;
        i_sq_retire_en = 1'b1; i_sq_retire_addr = 32'h0FE; i_sq_retire_lsu_func = LSU_FUNC_SH;
        #1;
        chk("bypass_sh_0xfe", 32'(o_rob_retire_misspeculated), 32'd0);
        tick();
        idle();

        // Miss waits on MHQ tag 1
        flush();
        alloc(6'd20, 32'h200, LSU_FUNC_LW);
        alloc(6'd21, 32'h204, LSU_FUNC_LW);
        alloc(6'd22, 32'h208, LSU_FUNC_LH);
        update(6'd22, 1'b0, 2'd1);
        i_mhq_fill = 1'b1; i_mhq_fill_tag = 2'd0;
        tick();
        idle();
        chk("fill0_no_replay", 32'(o_replay_en), 32'd0);
        i_mhq_fill = 1'b1; i_mhq_fill_tag = 2'd1;
        tick();
        idle();
        chk("fill1_replay_en", 32'(o_replay_en), 32'd1);
        chk("fill1_replay_tag", 32'(o_replay_tag), 32'd22);
        chk("fill1_replay_addr", o_replay_addr, 32'h208);
        chk("fill1_replay_func", 32'(o_replay_lsu_func), 32'(LSU_FUNC_LH));
        tick();
        chk("after_grant_idle", 32'(o_replay_en), 32'd0);

        // Round-robin over entries 1, 4, 6
        flush();
        for (int i = 0; i < 8; i++) alloc(6'(30 + i), 32'h400 + 32'(i) * 32'h4, LSU_FUNC_LW);
        update(6'd31, 1'b1, 2'd0);
        update(6'd34, 1'b1, 2'd0);
        update(6'd36, 1'b1, 2'd0);
        i_replay_stall = 1'b1; i_mhq_fill = 1'b1; i_mhq_fill_tag = 2'd2;
        tick();
        i_mhq_fill = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("stall_en", 32'(o_replay_en), 32'd0);
            chk("stall_tag", 32'(o_replay_tag), 32'd31);
            tick();
        end
        i_replay_stall = 1'b0;
        #1;
        chk("rr_grant_1", 32'(o_replay_tag), 32'd31);
        chk("rr_en_1", 32'(o_replay_en), 32'd1);
        tick();
        chk("rr_grant_4", 32'(o_replay_tag), 32'd34);
        tick();
        chk("rr_grant_6", 32'(o_replay_tag), 32'd36);
        tick();
        chk("rr_drained", 32'(o_replay_en), 32'd0);

        // Same-cycle update and matching fill, and wrap back to entry 1
        idle();
        i_update_en = 1'b1; i_update_tag = 6'd31; i_update_mhq_tag = 2'd2;
        i_mhq_fill = 1'b1; i_mhq_fill_tag = 2'd2;
        tick();
        idle();
        chk("race_wrap_en", 32'(o_replay_en), 32'd1);
        chk("race_wrap_tag", 32'(o_replay_tag), 32'd31);
        tick();
        i_update_en = 1'b1; i_update_tag = 6'd34; i_update_mhq_tag = 2'd3;
        i_mhq_fill = 1'b1; i_mhq_fill_tag = 2'd2;
        tick();
        idle();
        chk("race_nomatch_en", 32'(o_replay_en), 32'd0);
        i_mhq_fill = 1'b1; i_mhq_fill_tag = 2'd3;
        tick();
        idle();
        i_rob_retire_en = 1'b1; i_rob_retire_tag = 6'd34;
        #1;
        chk("retiring_excluded", 32'(o_replay_en), 32'd0);
        i_rob_retire_en = 1'b0;
        #1;
        chk("replay_tag_34", 32'(o_replay_tag), 32'd34);
        chk("replay_en_34", 32'(o_replay_en), 32'd1);
        chk("full_before_rst", 32'(o_full), 32'd1);

        // Reset in the middle of a replay
        rst = 1'b1;
        tick();
        chk("rst_replay_en", 32'(o_replay_en), 32'd0);
        chk("rst_full", 32'(o_full), 32'd0);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
